// File: rtl/mio_pkg.sv
// Shared types and IO map for the memory/IO bus responder.
// Optional cycle counter is enabled by MIO_COUNTER_EN.
package mio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_DONE = 2'd2
  } mio_state_e;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WAIT_W  = 4;
  localparam int unsigned LED_W   = 16;

  localparam logic [3:0]  IO_BASE    = 4'hF;
  localparam logic [27:0] SW_LED_OFS = 28'h000_0000;
  localparam logic [27:0] CNT_OFS    = 28'h000_0004;

  // Request as seen by the responder; bits [1:0] of the address are ignored
  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mio_req_t;

  function automatic logic io_word_hit(input logic [DATA_W-1:0] addr,
                                       input logic [27:0] ofs);
    return addr[27:2] == ofs[27:2];
  endfunction

endpackage

// File: rtl/mio_counter.sv
// Free-running 32-bit cycle counter with synchronous load (load beats increment).
// Instantiated only when MIO_COUNTER_EN is defined.
module mio_counter
  import mio_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] load_val,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] cnt_q;
  logic [DATA_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + DATA_W'(1);
    if (load) begin
      cnt_d = load_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q = cnt_q;

endmodule

// File: rtl/mio_bus_responder.sv
// Memory/IO responder for the multicycle CPU: block RAM with read wait states plus switch/LED IO.
// Define MIO_COUNTER_EN to add the cycle counter at 0xF000_0004.
module mio_bus_responder
  import mio_pkg::*;
#(
  parameter int unsigned RAM_AW      = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_r,
  input  logic              mem_w,
  input  logic [31:0]       M_addr,
  input  logic [31:0]       data_out,
  output logic [31:0]       data2CPU,
  output logic              MIO_ready,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  output logic              ram_we,
  input  logic [31:0]       ram_dout,
  input  logic [15:0]       sw,
  output logic [15:0]       led
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(WAIT_STATES);

  mio_req_t          req;
  mio_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LED_W-1:0]  led_q, led_d;
  logic              is_io;
  logic              hit_sw_led;
  logic              hit_cnt;
  logic [DATA_W-1:0] cnt_val;
  logic [DATA_W-1:0] io_rdata;
  logic              ram_we_c;
  logic              mio_ready_c;
  logic              cnt_load_c;
  logic              unused_addr_bits;

  assign req = '{rd: mem_r, wr: mem_w, addr: M_addr, wdata: data_out};

  assign is_io      = req.addr[31:28] == IO_BASE;
  assign hit_sw_led = is_io && io_word_hit(req.addr, SW_LED_OFS);
  assign hit_cnt    = is_io && io_word_hit(req.addr, CNT_OFS);
  assign unused_addr_bits = ^req.addr[1:0];

`ifdef MIO_COUNTER_EN
  mio_counter u_counter (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load_c),
    .load_val (req.wdata),
    .q        (cnt_val)
  );
`else
  assign cnt_val = '0;
`endif

  // Unmapped IO words read as zero
  always_comb begin
    io_rdata = '0;
    if (hit_sw_led) begin
      io_rdata = {16'b0, sw};
    end else if (hit_cnt) begin
      io_rdata = cnt_val;
    end
  end

  // Next-state and access control; a simultaneous read+write is a write
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    data_d      = data_q;
    led_d       = led_q;
    ram_we_c    = 1'b0;
    mio_ready_c = 1'b0;
    cnt_load_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        mio_ready_c = !req.rd && !req.wr;
        if (req.wr) begin
          state_d = ST_DONE;
          if (!is_io) begin
            ram_we_c = 1'b1;
          end else if (hit_sw_led) begin
            led_d = req.wdata[LED_W-1:0];
          end else if (hit_cnt) begin
            cnt_load_c = 1'b1;
          end
        end else if (req.rd) begin
          if (is_io) begin
            data_d  = io_rdata;
            state_d = ST_DONE;
          end else begin
            wait_d  = '0;
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (wait_q == LAST_WAIT) begin
          data_d  = ram_dout;
          wait_d  = '0;
          state_d = ST_DONE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DONE: begin
        mio_ready_c = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      data_q  <= '0;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      led_q   <= led_d;
    end
  end

  // Ready and write strobe respond to the request in the same cycle; reset forces idle behaviour
  assign MIO_ready = reset | mio_ready_c;
  assign ram_we    = ram_we_c & ~reset;
  assign ram_addr  = req.addr[RAM_AW+1:2];
  assign ram_din   = req.wdata;
  assign data2CPU  = data_q;
  assign led       = led_q;

endmodule

// File: doc/mio_bus_responder.md
# mio_bus_responder

Memory/IO bus responder at the far end of the multicycle CPU's memory port. It accepts the CPU's read and write requests (address, write data, read/write strobes) and decodes them to a synchronous block RAM or to memory-mapped IO. It returns read data and drives `MIO_ready`, which stalls the CPU. It inserts wait states for RAM reads, so the CPU's PC/IR/MDR updates only take effect once data is valid.

## Interface
Parameters:
- `RAM_AW`, 12: RAM word-address width; RAM spans 4·2^RAM_AW bytes from address 0.
- `WAIT_STATES`, 0: extra RAM read cycles beyond the RAM's 1-cycle latency (0–15).

Ports:
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `mem_r`  in  1: CPU read request.
- `mem_w`  in  1: CPU write request.
- `M_addr`  in  32: byte address from the CPU; bits [1:0] ignored.
- `data_out`  in  32: CPU write data.
- `data2CPU`  out  32: read data returned to the CPU, registered.
- `MIO_ready`  out  1: high = no access pending or access complete.
- `ram_addr`  out  RAM_AW: RAM word address, = `M_addr[RAM_AW+1:2]`.
- `ram_din`  out  32: RAM write data, = `data_out`.
- `ram_we`  out  1: RAM write strobe.
- `ram_dout`  in  32: RAM read data, valid 1 cycle after the address.
- `sw`  in  16: switch inputs.
- `led`  out  16: LED register.

## Operation
- Decode:
  - `M_addr[31:28]==4'hF` selects IO; anything else selects RAM.
  - IO map:
    - `0xF000_0000`: read returns `{16'b0,sw}`; write sets `led = data_out[15:0]`.
    - `0xF000_0004`: cycle counter (see Configuration).
  - Other IO addresses read 0, ignore writes, and still complete normally.
- FSM states:
  - IDLE → RD when `mem_r` is high and the address is RAM.
  - IDLE → DONE for any write, or for an IO read. IO read data is captured at the end of that IDLE cycle; the write is performed in that cycle.
  - RD lasts `1+WAIT_STATES` cycles, counted by a 4-bit wait counter. `ram_dout` is captured into `data2CPU` on the last RD cycle, then the FSM goes to DONE.
  - DONE → IDLE unconditionally after 1 cycle.
- `MIO_ready` = `(state==IDLE && !mem_r && !mem_w) || state==DONE`. This is combinational on the request in IDLE so the CPU stalls in the same cycle.
- `ram_we` = 1 only in IDLE with `mem_w` high and a RAM address; it lasts exactly one cycle.
- Handshake rules:
  - The CPU holds `mem_r`/`mem_w`, `M_addr` and `data_out` stable until it sees `MIO_ready` high.
  - A request still asserted in the cycle after DONE is a new access.
- `mem_r` and `mem_w` both high: treated as a write; `data2CPU` is unchanged.
- `data2CPU` holds its last captured value until the next read completes; writes never change it.

## Timing
- Reset values: state IDLE, `data2CPU`=0, `led`=0, wait counter 0, counter 0, `ram_we`=0. `MIO_ready`=1 while `reset` is high.
- RAM read, request in cycle T0:
  - `MIO_ready` is low for T0..T(1+WAIT_STATES).
  - `MIO_ready` is high in T(2+WAIT_STATES), with `data2CPU` valid in that cycle.
- IO read: `MIO_ready` is low for T0 and high in T1 with data valid.
- Write (RAM or IO): the write happens at the end of T0; `MIO_ready` is low for T0 and high in T1.
- Reset mid-access aborts it: the FSM returns to IDLE, no write occurs, and any partially completed read is discarded.

## Configuration
- `MIO_COUNTER_EN` defined:
  - A 32-bit counter increments every cycle.
  - A read of `0xF000_0004` returns its value as sampled in the request cycle.
  - A write loads `data_out`; the load takes priority over that cycle's increment.
- `MIO_COUNTER_EN` undefined: no counter logic; `0xF000_0004` reads 0 and ignores writes.

## Structure
- Package `mio_pkg`: FSM state encoding (IDLE, RD, DONE), IO base nibble `4'hF`, and IO offsets `SW_LED_OFS=0x0`, `CNT_OFS=0x4`.
- Sub-module `mio_counter` (clk, reset, load, load_val, q) is instantiated only under `MIO_COUNTER_EN`.

## Test plan
- Reset is held 3 cycles with `mem_r`=1 → `MIO_ready`=1, `led`=0, `data2CPU`=0, `ram_we` never asserted; after release, a request is accepted from IDLE.
- Write `0x0000_0010`=`0xDEADBEEF`, then read it with WAIT_STATES=0 → `ram_we` high for 1 cycle with `ram_addr`=4; on the read, `MIO_ready` is low for 2 cycles and `data2CPU`=`0xDEADBEEF` in the 3rd.
- WAIT_STATES=3, RAM read → `MIO_ready` is low for exactly 5 cycles.
- `sw`=`0x00A5`: read `0xF000_0000`, then write `0x1234ABCD` to it → read returns `0x000000A5` after 1 stall cycle; `led`=`0xABCD`; `ram_we` stays 0.
- With `MIO_COUNTER_EN`: write `0x100` to `0xF000_0004`, read 5 cycles after the write cycle → returns `0x104`. Without it → returns 0.
- `mem_r`=`mem_w`=1 at `0x20` with `data_out`=7, and separately reset asserted during RD → the first is treated as a write with `data2CPU` unchanged; the reset returns the FSM to IDLE with no capture.
